// File: rtl/axi_arb_pkg.sv
// Shared types for the 2:1 AXI4 DDR arbiter.
// Write/read FSM encodings and one-hot grant values.
package axi_arb_pkg;

    typedef enum logic [1:0] {WI, WA, WD, WB} wr_state_t;
    typedef enum logic [1:0] {RI, RA, RD} rd_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_S0   = 2'b01;
    localparam logic [1:0] GNT_S1   = 2'b10;

endpackage

// File: rtl/axi_ddr_arbiter_2to1_if.sv
// AXI4 burst bundle (AW/W/B/AR/R) used by both requesters and the DDR side.
// master drives requests, slave drives readys/responses.
interface axi_ddr_arbiter_2to1_if #(
    parameter int A_WIDTH = 26,
    parameter int D_WIDTH = 16
) ();

    logic               awvalid;
    logic               awready;
    logic [A_WIDTH-1:0] awaddr;
    logic [7:0]         awlen;
    logic               wvalid;
    logic               wready;
    logic [D_WIDTH-1:0] wdata;
    logic               wlast;
    logic               bvalid;
    logic               bready;
    logic               arvalid;
    logic               arready;
    logic [A_WIDTH-1:0] araddr;
    logic [7:0]         arlen;
    logic               rvalid;
    logic               rready;
    logic [D_WIDTH-1:0] rdata;
    logic               rlast;

    modport master (
        output awvalid, awaddr, awlen,
        output wvalid, wdata, wlast, bready,
        output arvalid, araddr, arlen, rready,
        input  awready, wready, bvalid,
        input  arready, rvalid, rdata, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen,
        input  wvalid, wdata, wlast, bready,
        input  arvalid, araddr, arlen, rready,
        output awready, wready, bvalid,
        output arready, rvalid, rdata, rlast
    );

endinterface

// File: rtl/axi_arb_rr2.sv
// 2-way round-robin picker; holds the grant for a whole transaction.
// Pointer remembers the last owner and moves only on done.
module axi_arb_rr2
    import axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       pick_en,
    input  logic       done,
    output logic [1:0] gnt
);

    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] pick;

    always_comb begin
        pick = GNT_NONE;
        unique case (req)
            2'b01:   pick = GNT_S0;
            2'b10:   pick = GNT_S1;
            2'b11:   pick = last_q ? GNT_S0 : GNT_S1;
            default: pick = GNT_NONE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt_q;
        last_d = last_q;
        if (done) begin
            gnt_d  = GNT_NONE;
            last_d = gnt_q[1];
        end else if (pick_en) begin
            gnt_d = pick;
        end
    end

    // last_q=1 means s1 was served last, so s0 wins the first tie
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt_q  <= GNT_NONE;
            last_q <= 1'b1;
        end else begin
            gnt_q  <= gnt_d;
            last_q <= last_d;
        end
    end

    assign gnt = gnt_q;

endmodule

// File: rtl/axi_ddr_arbiter_2to1.sv
// Shares one AXI4 DDR port between two burst masters.
// Write and read paths arbitrate independently, grant held per transaction.
module axi_ddr_arbiter_2to1
    import axi_arb_pkg::*;
#(
    parameter int A_WIDTH = 26,
    parameter int D_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    axi_ddr_arbiter_2to1_if.slave   s0,
    axi_ddr_arbiter_2to1_if.slave   s1,
    axi_ddr_arbiter_2to1_if.master  m,
    output logic [1:0]              wr_gnt,
    output logic [1:0]              rd_gnt
);

    wr_state_t wst_q, wst_d;
    rd_state_t rst_q, rst_d;
    logic      w_pick, w_done, r_pick, r_done;
    logic      w0, w1, r0, r1;

    logic [A_WIDTH-1:0] waddr_sel, raddr_sel;
    logic [D_WIDTH-1:0] wdata_sel;

    axi_arb_rr2 u_wr_rr (
        .clk     (clk),
        .rstn    (rstn),
        .req     ({s1.awvalid, s0.awvalid}),
        .pick_en (w_pick),
        .done    (w_done),
        .gnt     (wr_gnt)
    );

    axi_arb_rr2 u_rd_rr (
        .clk     (clk),
        .rstn    (rstn),
        .req     ({s1.arvalid, s0.arvalid}),
        .pick_en (r_pick),
        .done    (r_done),
        .gnt     (rd_gnt)
    );

    assign w0 = wr_gnt[0];
    assign w1 = wr_gnt[1];
    assign r0 = rd_gnt[0];
    assign r1 = rd_gnt[1];

    assign waddr_sel = w0 ? s0.awaddr : s1.awaddr;
    assign raddr_sel = r0 ? s0.araddr : s1.araddr;
    assign wdata_sel = w0 ? s0.wdata  : s1.wdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wst_q <= WI;
            rst_q <= RI;
        end else begin
            wst_q <= wst_d;
            rst_q <= rst_d;
        end
    end

    always_comb begin
        wst_d  = wst_q;
        w_pick = 1'b0;
        w_done = 1'b0;
        unique case (wst_q)
            WI: if (s0.awvalid || s1.awvalid) begin
                wst_d  = WA;
                w_pick = 1'b1;
            end
            WA: if (m.awvalid && m.awready) wst_d = WD;
            WD: if (m.wvalid && m.wready && m.wlast) wst_d = WB;
            WB: if (m.bvalid && m.bready) begin
                wst_d  = WI;
                w_done = 1'b1;
            end
            default: wst_d = WI;
        endcase
    end

    always_comb begin
        rst_d  = rst_q;
        r_pick = 1'b0;
        r_done = 1'b0;
        unique case (rst_q)
            RI: if (s0.arvalid || s1.arvalid) begin
                rst_d  = RA;
                r_pick = 1'b1;
            end
            RA: if (m.arvalid && m.arready) rst_d = RD;
            RD: if (m.rvalid && m.rready && m.rlast) begin
                rst_d  = RI;
                r_done = 1'b1;
            end
            default: rst_d = RI;
        endcase
    end

    always_comb begin
        m.awvalid  = 1'b0;
        m.awaddr   = '0;
        m.awlen    = '0;
        m.wvalid   = 1'b0;
        m.wdata    = '0;
        m.wlast    = 1'b0;
        m.bready   = 1'b0;
        s0.awready = 1'b0;
        s1.awready = 1'b0;
        s0.wready  = 1'b0;
        s1.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s1.bvalid  = 1'b0;
        unique case (wst_q)
            WA: begin
                m.awvalid  = w0 ? s0.awvalid : s1.awvalid;
                m.awaddr   = waddr_sel;
                m.awlen    = w0 ? s0.awlen : s1.awlen;
                s0.awready = w0 & m.awready;
                s1.awready = w1 & m.awready;
            end
            WD: begin
                m.wvalid  = w0 ? s0.wvalid : s1.wvalid;
                m.wdata   = wdata_sel;
                m.wlast   = w0 ? s0.wlast : s1.wlast;
                s0.wready = w0 & m.wready;
                s1.wready = w1 & m.wready;
            end
            WB: begin
                m.bready  = w0 ? s0.bready : s1.bready;
                s0.bvalid = w0 & m.bvalid;
                s1.bvalid = w1 & m.bvalid;
            end
            default: ;
        endcase
    end

    always_comb begin
        m.arvalid  = 1'b0;
        m.araddr   = '0;
        m.arlen    = '0;
        m.rready   = 1'b0;
        s0.arready = 1'b0;
        s1.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s1.rvalid  = 1'b0;
        s0.rlast   = 1'b0;
        s1.rlast   = 1'b0;
        s0.rdata   = '0;
        s1.rdata   = '0;
        unique case (rst_q)
            RA: begin
                m.arvalid  = r0 ? s0.arvalid : s1.arvalid;
                m.araddr   = raddr_sel;
                m.arlen    = r0 ? s0.arlen : s1.arlen;
                s0.arready = r0 & m.arready;
                s1.arready = r1 & m.arready;
            end
            RD: begin
                m.rready  = r0 ? s0.rready : s1.rready;
                s0.rvalid = r0 & m.rvalid;
                s1.rvalid = r1 & m.rvalid;
                s0.rlast  = r0 & m.rlast;
                s1.rlast  = r1 & m.rlast;
                s0.rdata  = r0 ? m.rdata : '0;
                s1.rdata  = r1 ? m.rdata : '0;
            end
            default: ;
        endcase
    end

endmodule
